// File: rtl/registrador_pilha.sv
// Undo stack of DEPTH words with sticky overflow/underflow flags and a
// registered random-access read port indexed from the top of the stack.
module registrador_pilha #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 9,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             enable,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  input  logic             rd_req,
  input  logic [AW-1:0]    rd_idx,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid
);

  typedef enum logic [2:0] {
    OP_IDLE      = 3'd0,
    OP_PUSH      = 3'd1,
    OP_POP       = 3'd2,
    OP_REPLACE   = 3'd3,
    OP_OVERFLOW  = 3'd4,
    OP_UNDERFLOW = 3'd5
  } op_e;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [CW-1:0]    count_r;
  logic             overflow_r;
  logic             underflow_r;
  logic [WIDTH-1:0] rd_data_r;
  logic             rd_valid_r;

  op_e              op_s;
  logic             empty_s;
  logic             full_s;
  logic [CW-1:0]    top_s;
  logic [CW-1:0]    rd_idx_ext_s;
  logic [CW-1:0]    rd_pos_s;
  logic             rd_hit_s;
  logic [WIDTH-1:0] q_s;

  assign empty_s      = (count_r == CW'(0));
  assign full_s       = (count_r == CW'(DEPTH));
  assign top_s        = count_r - CW'(1);
  assign rd_idx_ext_s = CW'(rd_idx);
  assign rd_pos_s     = top_s - rd_idx_ext_s;
  assign rd_hit_s     = (rd_idx_ext_s < count_r);

  // Decode the requested operation against the current occupancy.
  always_comb begin
    op_s = OP_IDLE;
    if (enable) begin
      case ({push, pop})
        2'b10:   op_s = full_s  ? OP_OVERFLOW  : OP_PUSH;
        2'b01:   op_s = empty_s ? OP_UNDERFLOW : OP_POP;
        2'b11:   op_s = empty_s ? OP_PUSH      : OP_REPLACE;
        default: op_s = OP_IDLE;
      endcase
    end else begin
      op_s = OP_IDLE;
    end
  end

  // Top-of-stack view; stale storage is hidden while empty.
  always_comb begin
    q_s = {WIDTH{1'b0}};
    if (empty_s) begin
      q_s = {WIDTH{1'b0}};
    end else begin
      q_s = mem_r[AW'(top_s)];
    end
  end

  // Storage array: no reset, pops never erase a word.
  always_ff @(posedge clock) begin
    if (!clear) begin
      case (op_s)
        OP_PUSH:    mem_r[AW'(count_r)] <= D;
        OP_REPLACE: mem_r[AW'(top_s)]   <= D;
        default:    ;
      endcase
    end
  end

  // Occupancy and sticky error flags.
  always_ff @(posedge clock) begin
    if (clear) begin
      count_r     <= {CW{1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      case (op_s)
        OP_PUSH:      count_r     <= count_r + CW'(1);
        OP_POP:       count_r     <= count_r - CW'(1);
        OP_OVERFLOW:  overflow_r  <= 1'b1;
        OP_UNDERFLOW: underflow_r <= 1'b1;
        default:      count_r     <= count_r;
      endcase
    end
  end

  // Read port samples the pre-edge stack; misses return zero.
  always_ff @(posedge clock) begin
    if (clear) begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= {WIDTH{1'b0}};
    end else if (enable && rd_req) begin
      rd_valid_r <= 1'b1;
      rd_data_r  <= rd_hit_s ? mem_r[AW'(rd_pos_s)] : {WIDTH{1'b0}};
    end else begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= rd_data_r;
    end
  end

  assign Q         = q_s;
  assign count     = count_r;
  assign empty     = empty_s;
  assign full      = full_s;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;
  assign rd_data   = rd_data_r;
  assign rd_valid  = rd_valid_r;

endmodule

// File: doc/registrador_pilha.md
REGISTRADOR_PILHA -- requirements
Module: registrador_pilha

Interface
REQ-001 SHALL have parameter WIDTH, default 9: bits per stored word.
REQ-002 SHALL have parameter DEPTH, default 9, legal range 2..64: number of stored words.
REQ-003 SHALL have localparam CW = clog2(DEPTH+1): width of the occupancy count.
REQ-004 SHALL have localparam AW = clog2(DEPTH): width of the read index.
REQ-005 clock  in  1  sole clock; every register updates on its rising edge.
REQ-006 clear  in  1  reset, synchronous and active-high.
REQ-007 enable  in  1  global qualifier; when 0, push, pop and rd_req are ignored.
REQ-008 push  in  1  write D onto the top of the stack.
REQ-009 pop  in  1  remove the top word (undo).
REQ-010 D  in  WIDTH  data word to push.
REQ-011 Q  out  WIDTH  current top word; all zeros when empty.
REQ-012 count  out  CW  number of stored words.
REQ-013 empty  out  1  high when count==0.
REQ-014 full  out  1  high when count==DEPTH.
REQ-015 overflow  out  1  sticky flag: a push was attempted while full.
REQ-016 underflow  out  1  sticky flag: a pop was attempted while empty.
REQ-017 rd_req  in  1  request to read the word at depth rd_idx below the top (0 = top).
REQ-018 rd_idx  in  AW  read index.
REQ-019 rd_data  out  WIDTH  registered read result.
REQ-020 rd_valid  out  1  one-cycle pulse qualifying rd_data.

Function
REQ-021 Q, empty and full SHALL be combinational decodes of the stored state, with no added latency.
REQ-022 Push when not full: D SHALL be stored at position count; count SHALL increment; Q SHALL equal D on the next cycle.
REQ-023 Pop when not empty: count SHALL decrement; Q SHALL show the previous word on the next cycle.
REQ-024 Stored words SHALL NOT be erased by a pop; only the occupancy changes.
REQ-025 Push and pop together when not empty: the top word SHALL be replaced by D and count SHALL be unchanged. This holds when full, and overflow SHALL NOT set.
REQ-026 Push and pop together when empty: the operation SHALL behave as a plain push, and underflow SHALL NOT set.
REQ-027 Push when full without pop: the push SHALL be ignored, state SHALL be unchanged, and overflow SHALL set.
REQ-028 Pop when empty without push: the pop SHALL be ignored and underflow SHALL set.
REQ-029 Overflow and underflow SHALL stay set until clear.
REQ-030 When rd_req=1 and enable=1 at an edge, the next cycle SHALL give rd_valid=1.
REQ-031 In that cycle, rd_data SHALL equal the word at position count-1-rd_idx, sampled before any same-edge push or pop.
REQ-032 When rd_idx >= count, rd_data SHALL be zero and rd_valid SHALL still pulse.
REQ-033 Without a qualifying request, rd_valid SHALL be 0 and rd_data SHALL hold its last value.
REQ-034 count SHALL never exceed DEPTH and SHALL never go below 0.

Reset
REQ-035 clear=1 at an edge SHALL set count=0, overflow=0, underflow=0, rd_valid=0 and rd_data=0, so that Q=0, empty=1 and full=0.
REQ-036 Clear SHALL take priority over enable, push, pop and rd_req in the same cycle.
REQ-037 A read pending at clear SHALL be dropped.
REQ-038 Storage array contents need not be reset; with count=0 they are unobservable through Q and rd_data.
REQ-039 Clear asserted mid-sequence SHALL discard all words.

Verification
REQ-040 Fill: with WIDTH=9 and DEPTH=9, push 9'h001..9'h009 -> count 9, full=1, Q=9'h009, overflow=0. A tenth push of 9'h0FF -> Q=9'h009, count 9, overflow=1.
REQ-041 Undo: from the fill state, 3 pops -> Q=9'h006, count 6. Then push 9'h100 -> Q=9'h100, count 7.
REQ-042 Underflow: after clear, pop -> count 0, underflow=1, Q=0. A following push 9'h0AA -> Q=9'h0AA, and underflow stays 1.
REQ-043 Replace: with count 3, push and pop together with D=9'h1FF -> count 3, Q=9'h1FF. With count 9 (full), the same -> top replaced, overflow=0.
REQ-044 Read port: with words 1,2,3 stored, rd_req and rd_idx=2 -> next cycle rd_valid=1, rd_data=9'h001. rd_idx=5 -> rd_data=0 with rd_valid=1.
REQ-045 Reset: clear at the same edge as push, pop and rd_req with count 4 -> count 0, empty=1, rd_valid=0, both sticky flags 0. enable=0 with push -> no change.
